// File: rtl/sonic_v1_15_debug_pkg.sv
// Shared defaults for the sonic v1.15 debug command bridge.
// Imported by the bridge top and its strobe synchronizer.
package sonic_v1_15_debug_pkg;

  localparam int IR_W_DEF  = 2;
  localparam int DR_W_DEF  = 38;
  localparam int SYNC_DEF  = 3;
  localparam int DEPTH_DEF = 4;
  localparam int ACT_BIT   = DR_W_DEF - 1;

  function automatic int act_bit(input int dr_w);
    return dr_w - 1;
  endfunction

endpackage

// File: rtl/sonic_v1_15_debug_sync.sv
// Level synchronizer plus registered rising-edge pulse.
// All chain flops reset high so a level held across reset is not an event.
module sonic_v1_15_debug_sync
  import sonic_v1_15_debug_pkg::*;
#(
  parameter int STAGES = SYNC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic [STAGES-1:0] s;
  logic              last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s     <= '1;
      last  <= 1'b1;
      pulse <= 1'b0;
    end else begin
      s     <= {s[STAGES-2:0], d};
      last  <= s[STAGES-1];
      pulse <= s[STAGES-1] & ~last;
    end
  end

endmodule

// File: rtl/sonic_v1_15_debug_cmd_bridge.sv
// Virtual-JTAG update-DR capture into a small command FIFO,
// with per-channel action strobes on pop and sticky overflow.
module sonic_v1_15_debug_cmd_bridge
  import sonic_v1_15_debug_pkg::*;
#(
  parameter int IR_W        = IR_W_DEF,
  parameter int DR_W        = DR_W_DEF,
  parameter int SYNC_STAGES = SYNC_DEF,
  parameter int DEPTH       = DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vs_udr,
  input  logic                 vs_uir,
  input  logic [IR_W-1:0]      ir_in,
  input  logic [DR_W-1:0]      sr,
  input  logic                 cmd_ready,
  input  logic                 ovf_clr,
  output logic                 cmd_valid,
  output logic [IR_W-1:0]      cmd_ir,
  output logic [DR_W-1:0]      jdo,
  output logic [2**IR_W-1:0]   take_action,
  output logic [2**IR_W-1:0]   take_no_action,
  output logic                 uir_pulse,
  output logic                 overflow,
  output logic [15:0]          cmd_count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int EW   = IR_W + DR_W;
  localparam int ABIT = act_bit(DR_W);

  logic          udr_p;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] occ;
  logic [15:0]   cnt_q;
  logic [EW-1:0] head;
  logic          full;
  logic          pop;
  logic          wr_en;

  sonic_v1_15_debug_sync #(.STAGES(SYNC_STAGES)) u_udr (
    .clk   (clk),
    .rst   (reset),
    .d     (vs_udr),
    .pulse (udr_p)
  );

  sonic_v1_15_debug_sync #(.STAGES(SYNC_STAGES)) u_uir (
    .clk   (clk),
    .rst   (reset),
    .d     (vs_uir),
    .pulse (uir_pulse)
  );

  assign full      = (occ == CW'(DEPTH));
  assign cmd_valid = (occ != '0);
  assign pop       = cmd_valid & cmd_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign wr_en     = udr_p & (~full | pop);
  assign head      = mem[rd_ptr];
  assign cmd_ir    = cmd_valid ? head[EW-1 -: IR_W] : '0;
  assign jdo       = cmd_valid ? head[DR_W-1:0] : '0;
  assign cmd_count = cnt_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {ir_in, sr};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      overflow <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        cnt_q  <= cnt_q + 16'd1;
      end
      unique case ({wr_en, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
      overflow <= (udr_p & full & ~pop) | (overflow & ~ovf_clr);
    end
  end

  always_comb begin
    take_action    = '0;
    take_no_action = '0;
    if (pop) begin
      if (jdo[ABIT]) take_action[cmd_ir]    = 1'b1;
      else           take_no_action[cmd_ir] = 1'b1;
    end
  end

endmodule

// File: tb/tb_sonic_v1_15_debug_cmd_bridge.sv
// Directed bench for the debug command bridge.
// Expected values are hand-derived from the cycle timing of the bridge.
module tb_sonic_v1_15_debug_cmd_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vs_udr = 1'b0;
  logic        vs_uir = 1'b0;
  logic [1:0]  ir_in = '0;
  logic [37:0] sr = '0;
  logic        cmd_ready = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        cmd_valid;
  logic [1:0]  cmd_ir;
  logic [37:0] jdo;
  logic [3:0]  take_action;
  logic [3:0]  take_no_action;
  logic        uir_pulse;
  logic        overflow;
  logic [15:0] cmd_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sonic_v1_15_debug_cmd_bridge dut (
    .clk            (clk),
    .reset          (reset),
    .vs_udr         (vs_udr),
    .vs_uir         (vs_uir),
    .ir_in          (ir_in),
    .sr             (sr),
    .cmd_ready      (cmd_ready),
    .ovf_clr        (ovf_clr),
    .cmd_valid      (cmd_valid),
    .cmd_ir         (cmd_ir),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .uir_pulse      (uir_pulse),
    .overflow       (overflow),
    .cmd_count      (cmd_count)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Raise vs_udr at a negedge (N0); the entry lands at the 5th posedge.
  task automatic set_cmd(input logic [1:0] ir, input logic act,
                         input logic [31:0] d);
    ir_in  = ir;
    sr     = {act, 5'd0, d};
    vs_udr = 1'b1;
  endtask

  task automatic push_cmd(input logic [1:0] ir, input logic act,
                          input logic [31:0] d);
    @(negedge clk);
    set_cmd(ir, act, d);
    repeat (2) @(negedge clk);
    vs_udr = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic pop_one(input string tag, input logic [31:0] d);
    @(negedge clk);
    chk(tag, {32'd0, jdo[31:0]}, {32'd0, d});
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
  endtask

  initial begin
    int nt;
    int nu;
    logic [3:0] ta_or;
    logic [3:0] tn_val;

    repeat (2) @(negedge clk);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_jdo", jdo, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cnt", cmd_count, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // first command: latency and action strobe
    cmd_ready = 1'b1;
    set_cmd(2'b01, 1'b1, 32'hDEADBEEF);
    repeat (2) @(negedge clk);
    vs_udr = 1'b0;
    repeat (2) @(negedge clk);
    chk("lat_early", cmd_valid, 0);
    @(negedge clk);
    chk("lat_valid", cmd_valid, 1);
    chk("t1_ir", cmd_ir, 2'b01);
    chk("t1_jdo", jdo[31:0], 32'hDEADBEEF);
    chk("t1_act", take_action, 4'b0010);
    chk("t1_noact", take_no_action, 0);
    @(negedge clk);
    chk("t1_empty", cmd_valid, 0);
    chk("t1_act_off", take_action, 0);
    chk("t1_cnt", cmd_count, 1);
    cmd_ready = 1'b0;

    // overflow on fifth push, FIFO order preserved
    do_reset();
    for (int i = 1; i <= 5; i++) push_cmd(2'(i), 1'b1, 32'(i));
    chk("ovf_set", overflow, 1);
    chk("ovf_valid", cmd_valid, 1);
    for (int i = 1; i <= 4; i++) pop_one("drain_ord", 32'(i));
    @(negedge clk);
    chk("drain_empty", cmd_valid, 0);
    chk("drain_cnt", cmd_count, 4);

    // full FIFO: push coincident with pop is accepted
    do_reset();
    for (int i = 1; i <= 4; i++) push_cmd(2'b00, 1'b1, 32'(i));
    chk("full_noovf", overflow, 0);
    @(negedge clk);
    set_cmd(2'b00, 1'b1, 32'd5);
    repeat (2) @(negedge clk);
    vs_udr = 1'b0;
    repeat (2) @(negedge clk);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    chk("pp_ovf", overflow, 0);
    for (int i = 2; i <= 5; i++) pop_one("pp_ord", 32'(i));
    @(negedge clk);
    chk("pp_empty", cmd_valid, 0);

    // drop sets overflow; set beats a coincident clear
    for (int i = 6; i <= 10; i++) push_cmd(2'b00, 1'b1, 32'(i));
    chk("drop_ovf", overflow, 1);
    @(negedge clk);
    set_cmd(2'b00, 1'b1, 32'd11);
    repeat (2) @(negedge clk);
    vs_udr = 1'b0;
    repeat (2) @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("set_wins", overflow, 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_clr", overflow, 0);
    for (int i = 6; i <= 9; i++) pop_one("drop_ord", 32'(i));
    @(negedge clk);
    chk("drop_empty", cmd_valid, 0);

    // mid-operation reset discards queue at once
    push_cmd(2'b10, 1'b1, 32'd21);
    push_cmd(2'b10, 1'b1, 32'd22);
    chk("mid_valid", cmd_valid, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", cmd_valid, 0);
    @(negedge clk);
    cmd_ready = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    chk("rel_act", take_action, 0);
    chk("rel_noact", take_no_action, 0);
    cmd_ready = 1'b0;

    // udr held across reset release; then one uir event
    vs_udr = 1'b1;
    do_reset();
    repeat (8) @(negedge clk);
    chk("held_udr", cmd_valid, 0);
    vs_udr = 1'b0;
    repeat (6) @(negedge clk);
    nu = 0;
    vs_uir = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) vs_uir = 1'b0;
      if (uir_pulse) nu++;
    end
    chk("uir_once", 64'(nu), 1);
    chk("uir_noq", cmd_valid, 0);

    // no-action strobe on channel 3
    cmd_ready = 1'b1;
    nt = 0;
    ta_or = '0;
    tn_val = '0;
    @(negedge clk);
    set_cmd(2'b11, 1'b0, 32'h55);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 1) vs_udr = 1'b0;
      ta_or = ta_or | take_action;
      if (take_no_action != 0) begin
        nt++;
        tn_val = take_no_action;
      end
    end
    chk("noact_cycles", 64'(nt), 1);
    chk("noact_val", tn_val, 4'b1000);
    chk("noact_ta", ta_or, 0);

    // count wrap
    @(negedge clk);
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    push_cmd(2'b00, 1'b1, 32'h77);
    chk("cnt_wrap", cmd_count, 0);
    cmd_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
